// File: rtl/pokey_pkg.sv
// Shared types and default timing constants for the POKEY blocks.
package pokey_pkg;

    typedef enum logic [1:0] {
        POT_IDLE,
        POT_DUMP,
        POT_SCAN
    } pot_state_t;

    localparam int unsigned POT_MAX_COUNT_DEF   = 228;
    localparam int unsigned POT_DUMP_CYCLES_DEF = 4;

endpackage

// File: rtl/pot_channel.sv
// One paddle channel: comparator synchroniser, latched count and scan-in-progress bit.
module pot_channel #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned MAX_COUNT   = 228,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             o2,
    input  logic             n_reset,
    input  logic             pot_in,
    input  logic             clear,
    input  logic             scan_en,
    input  logic             force_max,
    input  logic [CNT_W-1:0] counter,
    output logic [CNT_W-1:0] pot_val,
    output logic             allpot
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   seen;

    assign seen = sync_q[SYNC_STAGES-1];

    always_ff @(posedge o2 or negedge n_reset) begin
        if (!n_reset) begin
            sync_q  <= '0;
            pot_val <= '0;
            allpot  <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(pot_in);
            if (clear) begin
                allpot <= 1'b1;
            end else if (allpot && scan_en && (seen || force_max)) begin
                // A crossing on the terminal tick still reads as the terminal count.
                pot_val <= force_max ? CNT_W'(MAX_COUNT) : counter;
                allpot  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pokey_pot_scanner.sv
// N-channel pot scanner: capacitor dump, scan counter and per-channel count latching.
module pokey_pot_scanner
    import pokey_pkg::*;
#(
    parameter int unsigned NUM_POTS    = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned MAX_COUNT   = POT_MAX_COUNT_DEF,
    parameter int unsigned DUMP_CYCLES = POT_DUMP_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      o2,
    input  logic                      n_reset,
    input  logic                      potgo,
    input  logic                      fast_scan,
    input  logic                      scan_clk_en,
    input  logic [NUM_POTS-1:0]       pot_in,
    output logic [NUM_POTS-1:0]       pot_dump,
    output logic [NUM_POTS*CNT_W-1:0] pot_val,
    output logic [NUM_POTS-1:0]       allpot,
    output logic                      scan_busy,
    output logic                      scan_done
);

    localparam int unsigned        TIMER_W   = (DUMP_CYCLES > 1) ? $clog2(DUMP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MAX_COUNT);
    localparam logic [TIMER_W-1:0] DUMP_LAST = TIMER_W'(DUMP_CYCLES - 1);

    pot_state_t         state;
    logic [CNT_W-1:0]   counter;
    logic [TIMER_W-1:0] timer;
    logic               dump;
    logic               tick;
    logic               at_max;
    logic               scan_en;
    logic               force_max;
    logic               all_clear;

    assign tick      = fast_scan | scan_clk_en;
    assign at_max    = (counter == MAX_CNT);
    // A restart strobe wins over any latching in the same cycle.
    assign scan_en   = (state == POT_SCAN) & ~potgo;
    assign force_max = scan_en & tick & at_max;
    assign all_clear = ~|allpot;
    assign pot_dump  = {NUM_POTS{dump}};

    always_ff @(posedge o2 or negedge n_reset) begin
        if (!n_reset) begin
            state     <= POT_IDLE;
            counter   <= '0;
            timer     <= '0;
            dump      <= 1'b0;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (potgo) begin
                state     <= POT_DUMP;
                counter   <= '0;
                timer     <= '0;
                dump      <= 1'b1;
                scan_busy <= 1'b1;
            end else begin
                unique case (state)
                    POT_IDLE: begin
                    end
                    POT_DUMP: begin
                        if (timer == DUMP_LAST) begin
                            state <= POT_SCAN;
                            dump  <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    POT_SCAN: begin
                        if ((tick && at_max) || all_clear) begin
                            state     <= POT_IDLE;
                            scan_busy <= 1'b0;
                            scan_done <= 1'b1;
                        end else if (tick) begin
                            counter <= counter + 1'b1;
                        end
                    end
                    default: state <= POT_IDLE;
                endcase
            end
        end
    end

    for (genvar n = 0; n < NUM_POTS; n++) begin : g_chan
        pot_channel #(
            .CNT_W      (CNT_W),
            .MAX_COUNT  (MAX_COUNT),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chan (
            .o2       (o2),
            .n_reset  (n_reset),
            .pot_in   (pot_in[n]),
            .clear    (potgo),
            .scan_en  (scan_en),
            .force_max(force_max),
            .counter  (counter),
            .pot_val  (pot_val[n*CNT_W +: CNT_W]),
            .allpot   (allpot[n])
        );
    end

endmodule

// File: tb/tb_pokey_pot_scanner.sv
// Scoreboarded bench for pokey_pot_scanner: default-ish 4-pot build plus a wide 8-pot build.
module tb_pokey_pot_scanner;

    localparam int NP = 4, CW = 8, MAXC = 228, DC = 4, SS = 2;
    localparam int NP2 = 8, CW2 = 9, MAXC2 = 300;
    localparam int SLOW_TICKS = 100, SLOW_PERIOD = 114;

    logic o2 = 1'b0;
    always #5 o2 = ~o2;

    logic              n_reset, potgo, fast_scan, scan_clk_en;
    logic [NP-1:0]     pot_in, pot_dump, allpot;
    logic [NP*CW-1:0]  pot_val;
    logic              scan_busy, scan_done;

    logic              potgo_big;
    logic [NP2-1:0]    pot_in_big, pot_dump_big, allpot_big;
    logic [NP2*CW2-1:0] pot_val_big;
    logic              busy_big, done_big;

    typedef struct {
        logic [71:0] vals;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pokey_pot_scanner #(
        .NUM_POTS(NP), .CNT_W(CW), .MAX_COUNT(MAXC), .DUMP_CYCLES(DC), .SYNC_STAGES(SS)
    ) dut (
        .o2(o2), .n_reset(n_reset), .potgo(potgo), .fast_scan(fast_scan),
        .scan_clk_en(scan_clk_en), .pot_in(pot_in), .pot_dump(pot_dump), .pot_val(pot_val),
        .allpot(allpot), .scan_busy(scan_busy), .scan_done(scan_done)
    );

    pokey_pot_scanner #(
        .NUM_POTS(NP2), .CNT_W(CW2), .MAX_COUNT(MAXC2), .DUMP_CYCLES(DC), .SYNC_STAGES(SS)
    ) dut_big (
        .o2(o2), .n_reset(n_reset), .potgo(potgo_big), .fast_scan(1'b1),
        .scan_clk_en(1'b0), .pot_in(pot_in_big), .pot_dump(pot_dump_big),
        .pot_val(pot_val_big), .allpot(allpot_big), .scan_busy(busy_big),
        .scan_done(done_big)
    );

    task automatic step();
        @(posedge o2);
        #1;
    endtask

    task automatic pulse_potgo();
        potgo = 1'b1;
        step();
        potgo = 1'b0;
    endtask

    task automatic wait_done(input bit big, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ((big ? done_big : scan_done) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b1;
        #2 n_reset = 1'b0;
        step();
        step();
        n_cmp++;
        if ({pot_dump, allpot, scan_busy, scan_done} !== '0) begin
            n_bad++;
            $display("FAIL reset_flags: actual dump=%b allpot=%b busy=%b done=%b required all 0",
                     pot_dump, allpot, scan_busy, scan_done);
        end
        n_cmp++;
        if (pot_val !== '0) begin
            n_bad++;
            $display("FAIL reset_val: actual %h required 0", pot_val);
        end
        n_reset = 1'b1;
        step();
        n_cmp++;
        if ({pot_dump, allpot, scan_busy, scan_done, pot_val} !== '0) begin
            n_bad++;
            $display("FAIL reset_idle: actual busy=%b allpot=%b required idle", scan_busy, allpot);
        end
    endtask

    task automatic test_fast_scan();
        exp_t e;
        int   elapsed, lat, dump_cnt;
        bit   ok;
        logic [NP-1:0] want_ap;
        e.vals = '0;
        for (int ch = 0; ch < NP; ch++) e.vals[ch*CW +: CW] = (ch == 0) ? CW'(30 + SS) : CW'(MAXC);
        e.lat = DC + MAXC + 1;
        sb.push_back(e);
        fast_scan = 1'b1;
        pot_in    = '0;
        pulse_potgo();
        elapsed  = 0;
        dump_cnt = 0;
        for (int i = 0; i < DC + 1; i++) begin
            if (pot_dump === '1) dump_cnt++;
            step();
            elapsed++;
        end
        n_cmp++;
        if (dump_cnt !== DC) begin
            n_bad++;
            $display("FAIL fast_dump_len: actual %0d required %0d", dump_cnt, DC);
        end
        repeat (29) begin
            step();
            elapsed++;
        end
        pot_in[0] = 1'b1;
        repeat (SS) begin
            step();
            elapsed++;
        end
        n_cmp++;
        if (allpot !== {NP{1'b1}}) begin
            n_bad++;
            $display("FAIL fast_allpot_pre: actual %b required %b", allpot, {NP{1'b1}});
        end
        step();
        elapsed++;
        want_ap = {{(NP-1){1'b1}}, 1'b0};
        n_cmp++;
        if (allpot !== want_ap) begin
            n_bad++;
            $display("FAIL fast_allpot_mid: actual %b required %b", allpot, want_ap);
        end
        wait_done(1'b0, lat, ok);
        elapsed += lat;
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL fast_timeout: actual no scan_done required scan_done");
        end
        n_cmp++;
        if ({allpot, scan_busy} !== '0) begin
            n_bad++;
            $display("FAIL fast_end_flags: actual allpot=%b busy=%b required 0", allpot, scan_busy);
        end
        e = sb.pop_front();
        for (int ch = 0; ch < NP; ch++) begin
            n_cmp++;
            if (pot_val[ch*CW +: CW] !== e.vals[ch*CW +: CW]) begin
                n_bad++;
                $display("FAIL fast_val%0d: actual %0d required %0d", ch, pot_val[ch*CW +: CW],
                         e.vals[ch*CW +: CW]);
            end
        end
        n_cmp++;
        if (elapsed !== e.lat) begin
            n_bad++;
            $display("FAIL fast_latency: actual %0d required %0d", elapsed, e.lat);
        end
        step();
        n_cmp++;
        if (scan_done !== 1'b0) begin
            n_bad++;
            $display("FAIL fast_done_width: actual %b required 0", scan_done);
        end
        pot_in = '0;
        repeat (SS + 1) step();
    endtask

    task automatic test_held_high();
        exp_t e;
        int   elapsed, lat;
        bit   ok;
        e.vals = '0;
        e.lat  = DC + 2;
        sb.push_back(e);
        fast_scan = 1'b1;
        pot_in    = '1;
        repeat (SS + 1) step();
        pulse_potgo();
        elapsed = 0;
        repeat (DC) begin
            step();
            elapsed++;
        end
        n_cmp++;
        if (allpot !== {NP{1'b1}}) begin
            n_bad++;
            $display("FAIL held_no_dump_latch: actual %b required %b", allpot, {NP{1'b1}});
        end
        wait_done(1'b0, lat, ok);
        elapsed += lat;
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL held_timeout: actual no scan_done required scan_done");
        end
        e = sb.pop_front();
        n_cmp++;
        if ({8'h00, pot_val} !== e.vals[NP*CW+8-1:0]) begin
            n_bad++;
            $display("FAIL held_vals: actual %h required %h", pot_val, e.vals[NP*CW-1:0]);
        end
        n_cmp++;
        if (elapsed !== e.lat) begin
            n_bad++;
            $display("FAIL held_latency: actual %0d required %0d", elapsed, e.lat);
        end
        pot_in = '0;
        repeat (SS + 1) step();
    endtask

    task automatic test_slow_scan();
        exp_t e;
        int   lat;
        bit   ok;
        e.vals = '0;
        for (int ch = 0; ch < NP; ch++) e.vals[ch*CW +: CW] = CW'(SLOW_TICKS);
        e.lat = SS + 2;
        sb.push_back(e);
        fast_scan   = 1'b0;
        scan_clk_en = 1'b0;
        pot_in      = '0;
        pulse_potgo();
        repeat (DC) step();
        for (int t = 0; t < SLOW_TICKS; t++) begin
            repeat (SLOW_PERIOD - 1) step();
            scan_clk_en = 1'b1;
            step();
            scan_clk_en = 1'b0;
        end
        n_cmp++;
        if ({allpot, scan_busy} !== {{NP{1'b1}}, 1'b1}) begin
            n_bad++;
            $display("FAIL slow_in_progress: actual allpot=%b busy=%b required all 1",
                     allpot, scan_busy);
        end
        pot_in = '1;
        wait_done(1'b0, lat, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL slow_timeout: actual no scan_done required scan_done");
        end
        e = sb.pop_front();
        for (int ch = 0; ch < NP; ch++) begin
            n_cmp++;
            if (pot_val[ch*CW +: CW] !== e.vals[ch*CW +: CW]) begin
                n_bad++;
                $display("FAIL slow_val%0d: actual %0d required %0d", ch, pot_val[ch*CW +: CW],
                         e.vals[ch*CW +: CW]);
            end
        end
        n_cmp++;
        if (lat !== e.lat) begin
            n_bad++;
            $display("FAIL slow_latency: actual %0d required %0d", lat, e.lat);
        end
        pot_in    = '0;
        fast_scan = 1'b1;
        repeat (SS + 1) step();
    endtask

    task automatic test_restart();
        exp_t e;
        int   elapsed, lat, dump_cnt, done_cnt;
        bit   ok;
        e.vals = '0;
        e.vals[0*CW +: CW] = CW'(MAXC);
        e.vals[1*CW +: CW] = CW'(0);
        e.vals[2*CW +: CW] = CW'(10 + SS);
        e.vals[3*CW +: CW] = CW'(MAXC);
        e.lat = DC + MAXC + 1;
        sb.push_back(e);
        fast_scan = 1'b1;
        pot_in    = '0;
        pulse_potgo();
        repeat (DC) step();
        repeat (20) step();
        pot_in[1] = 1'b1;
        done_cnt  = 0;
        repeat (100) begin
            step();
            if (scan_done === 1'b1) done_cnt++;
        end
        n_cmp++;
        if (pot_val[1*CW +: CW] !== CW'(20 + SS)) begin
            n_bad++;
            $display("FAIL restart_first_latch: actual %0d required %0d", pot_val[1*CW +: CW],
                     20 + SS);
        end
        pulse_potgo();
        elapsed  = 0;
        dump_cnt = 0;
        n_cmp++;
        if (pot_val[0*CW +: CW] !== CW'(SLOW_TICKS)) begin
            n_bad++;
            $display("FAIL restart_retain0: actual %0d required %0d", pot_val[0*CW +: CW],
                     SLOW_TICKS);
        end
        for (int i = 0; i < DC + 1; i++) begin
            if (pot_dump === '1) dump_cnt++;
            if (scan_done === 1'b1) done_cnt++;
            step();
            elapsed++;
        end
        n_cmp++;
        if (dump_cnt !== DC) begin
            n_bad++;
            $display("FAIL restart_dump_len: actual %0d required %0d", dump_cnt, DC);
        end
        n_cmp++;
        if (done_cnt !== 0) begin
            n_bad++;
            $display("FAIL restart_abort_done: actual %0d pulses required 0", done_cnt);
        end
        n_cmp++;
        if ({pot_val[0*CW +: CW], pot_val[1*CW +: CW]} !== {CW'(SLOW_TICKS), CW'(0)}) begin
            n_bad++;
            $display("FAIL restart_relatch: actual ch0=%0d ch1=%0d required ch0=%0d ch1=0",
                     pot_val[0*CW +: CW], pot_val[1*CW +: CW], SLOW_TICKS);
        end
        repeat (9) begin
            step();
            elapsed++;
        end
        pot_in[2] = 1'b1;
        wait_done(1'b0, lat, ok);
        elapsed += lat;
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_timeout: actual no scan_done required scan_done");
        end
        e = sb.pop_front();
        for (int ch = 0; ch < NP; ch++) begin
            n_cmp++;
            if (pot_val[ch*CW +: CW] !== e.vals[ch*CW +: CW]) begin
                n_bad++;
                $display("FAIL restart_val%0d: actual %0d required %0d", ch,
                         pot_val[ch*CW +: CW], e.vals[ch*CW +: CW]);
            end
        end
        n_cmp++;
        if (elapsed !== e.lat) begin
            n_bad++;
            $display("FAIL restart_latency: actual %0d required %0d", elapsed, e.lat);
        end
        pot_in = '0;
        repeat (SS + 1) step();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        bit   ok;
        fast_scan = 1'b1;
        pot_in    = '0;
        pulse_potgo();
        step();
        n_reset = 1'b0;
        #1;
        n_cmp++;
        if ({pot_dump, scan_busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_in_dump: actual dump=%b busy=%b required 0", pot_dump, scan_busy);
        end
        n_reset = 1'b1;
        step();
        pulse_potgo();
        repeat (DC + 50) step();
        n_cmp++;
        if (scan_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_busy: actual %b required 1", scan_busy);
        end
        n_reset = 1'b0;
        #1;
        n_cmp++;
        if ({pot_dump, allpot, scan_busy, scan_done, pot_val} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_async: actual allpot=%b busy=%b val=%h required all 0",
                     allpot, scan_busy, pot_val);
        end
        step();
        n_reset = 1'b1;
        step();
        e.vals = '0;
        for (int ch = 0; ch < NP; ch++) e.vals[ch*CW +: CW] = CW'(MAXC);
        e.lat = DC + MAXC + 1;
        sb.push_back(e);
        pulse_potgo();
        wait_done(1'b0, lat, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_rescan_timeout: actual no scan_done required scan_done");
        end
        e = sb.pop_front();
        n_cmp++;
        if ({8'h00, pot_val} !== e.vals[NP*CW+8-1:0]) begin
            n_bad++;
            $display("FAIL reset_rescan_vals: actual %h required %h", pot_val, e.vals[NP*CW-1:0]);
        end
        n_cmp++;
        if (lat !== e.lat) begin
            n_bad++;
            $display("FAIL reset_rescan_latency: actual %0d required %0d", lat, e.lat);
        end
    endtask

    task automatic test_wide();
        exp_t e;
        int   lat;
        bit   ok;
        e.vals = '0;
        for (int ch = 0; ch < NP2; ch++) e.vals[ch*CW2 +: CW2] = CW2'(MAXC2);
        e.lat = DC + MAXC2 + 1;
        sb.push_back(e);
        pot_in_big = '0;
        potgo_big  = 1'b1;
        step();
        potgo_big  = 1'b0;
        wait_done(1'b1, lat, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL wide_timeout: actual no scan_done required scan_done");
        end
        e = sb.pop_front();
        for (int ch = 0; ch < NP2; ch++) begin
            n_cmp++;
            if (pot_val_big[ch*CW2 +: CW2] !== e.vals[ch*CW2 +: CW2]) begin
                n_bad++;
                $display("FAIL wide_val%0d: actual %0d required %0d", ch,
                         pot_val_big[ch*CW2 +: CW2], e.vals[ch*CW2 +: CW2]);
            end
        end
        n_cmp++;
        if (lat !== e.lat) begin
            n_bad++;
            $display("FAIL wide_latency: actual %0d required %0d", lat, e.lat);
        end
        n_cmp++;
        if ({allpot_big, busy_big, pot_dump_big} !== '0) begin
            n_bad++;
            $display("FAIL wide_end_flags: actual allpot=%b busy=%b required 0",
                     allpot_big, busy_big);
        end
    endtask

    initial begin
        n_reset     = 1'b1;
        potgo       = 1'b0;
        potgo_big   = 1'b0;
        fast_scan   = 1'b1;
        scan_clk_en = 1'b0;
        pot_in      = '0;
        pot_in_big  = '0;
        test_reset();
        test_fast_scan();
        test_held_high();
        test_slow_scan();
        test_restart();
        test_reset_mid();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
